// File: rtl/riscv_ai_chip_top.sv
// Chip-level HBM-to-PCIe smoke path: per-channel word FIFOs drained round-robin into a rotating XOR signature.
// Latency: push-to-pop >= 1 cycle, signature-to-TX 1 cycle; backpressure via hbm_ready when a channel FIFO is full.

// Small circular FIFO with occupancy count and synchronous flush.
// Latency: a word written at edge N is visible on pop_dat after edge N.
// Backpressure: none internally; the caller gates push on count < DEPTH and pop on count != 0.
module hbm_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    push_dat,
    output logic [W-1:0]    pop_dat,
    output logic [CNTW-1:0] count
);
    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
endmodule

// Top-level shell: HBM channel ingest, round-robin drain, 32-bit signature, PCIe TX exposure.
// Latency: en loads 1 cycle after hbm_rst_n; pop >= 1 cycle after push; TX 1 cycle after csum.
// Backpressure: hbm_ready[c] drops when channel c holds 4 words or is disabled; no full-FIFO bypass.
module riscv_ai_chip_top #(
    parameter int HBM_CHANNELS   = 4,
    parameter int HBM_DATA_WIDTH = 64,
    parameter int PCIE_LANES     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [HBM_CHANNELS-1:0]                hbm_clk,
    input  logic [HBM_CHANNELS-1:0]                hbm_rst_n,
    input  logic [HBM_CHANNELS*HBM_DATA_WIDTH-1:0] hbm_dq,
    input  logic [HBM_CHANNELS-1:0]                hbm_valid,
    output logic [HBM_CHANNELS-1:0]                hbm_ready,
    input  logic                                   pcie_clk,
    input  logic                                   pcie_rst_n,
    input  logic [PCIE_LANES-1:0]                  pcie_rx_p,
    input  logic [PCIE_LANES-1:0]                  pcie_rx_n,
    output logic [PCIE_LANES-1:0]                  pcie_tx_p,
    output logic [PCIE_LANES-1:0]                  pcie_tx_n
);
    localparam int W          = HBM_DATA_WIDTH;
    localparam int CW         = (HBM_CHANNELS > 1) ? $clog2(HBM_CHANNELS) : 1;
    localparam int FIFO_DEPTH = 4;
    localparam int CNTW       = $clog2(FIFO_DEPTH + 1);

    logic [HBM_CHANNELS-1:0] en_q, en_d;
    logic [CW-1:0]           rr_q, rr_d;
    logic [31:0]             csum_q, csum_d;
    logic [PCIE_LANES-1:0]   tx_p_q, tx_p_d;
    logic [PCIE_LANES-1:0]   tx_n_q, tx_n_d;

    logic [HBM_CHANNELS-1:0] push_vld, pop_vld, nonempty;
    logic [W-1:0]            fifo_dat [HBM_CHANNELS];
    logic [CNTW-1:0]         fifo_cnt [HBM_CHANNELS];
    logic                    sel_vld;
    logic [CW-1:0]           sel;
    logic [W-1:0]            pop_dat;
    logic [31:0]             fold;
    logic                    link;

    // Pin-compatibility clocks; the whole block runs on clk.
    logic unused_clks;
    assign unused_clks = ^{hbm_clk, pcie_clk};

    for (genvar c = 0; c < HBM_CHANNELS; c++) begin : g_ch
        assign push_vld[c]  = hbm_valid[c] & hbm_ready[c];
        assign pop_vld[c]   = sel_vld & (sel == CW'(c));
        assign hbm_ready[c] = en_q[c] & (fifo_cnt[c] < CNTW'(FIFO_DEPTH));
        assign nonempty[c]  = en_q[c] & (fifo_cnt[c] != '0);

        hbm_fifo #(
            .W     (W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (~en_q[c]),
            .push     (push_vld[c]),
            .pop      (pop_vld[c]),
            .push_dat (hbm_dq[c*W +: W]),
            .pop_dat  (fifo_dat[c]),
            .count    (fifo_cnt[c])
        );
    end

    // First occupied enabled channel at or after rr_q wins the single drain slot.
    always_comb begin
        int idx_i;
        logic [CW-1:0] idx;
        sel_vld = 1'b0;
        sel     = '0;
        idx_i   = 0;
        idx     = '0;
        for (int k = 0; k < HBM_CHANNELS; k++) begin
            idx_i = (int'(rr_q) + k) % HBM_CHANNELS;
            idx   = CW'(idx_i);
            if (!sel_vld && nonempty[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        pop_dat = fifo_dat[sel];
        fold    = '0;
        for (int s = 0; s < W / 32; s++) begin
            fold = fold ^ pop_dat[s*32 +: 32];
        end

        en_d   = hbm_rst_n;
        rr_d   = rr_q;
        csum_d = csum_q;
        if (sel_vld) begin
            rr_d   = (int'(sel) == HBM_CHANNELS - 1) ? '0 : sel + CW'(1);
            csum_d = {csum_q[30:0], csum_q[31]} ^ fold;
        end

        link   = &(pcie_rx_p ^ pcie_rx_n);
        tx_p_d = (pcie_rst_n & link) ? csum_q[PCIE_LANES-1:0] : '0;
        tx_n_d = pcie_rst_n ? ~tx_p_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            rr_q   <= '0;
            csum_q <= '0;
            tx_p_q <= '0;
            tx_n_q <= '0;
        end else begin
            en_q   <= en_d;
            rr_q   <= rr_d;
            csum_q <= csum_d;
            tx_p_q <= tx_p_d;
            tx_n_q <= tx_n_d;
        end
    end

    assign pcie_tx_p = tx_p_q;
    assign pcie_tx_n = tx_n_q;
endmodule

// File: tb/tb_riscv_ai_chip_top.sv
// Directed bench for riscv_ai_chip_top: hand-computed vector table plus model-checked multi-cycle sequences.
module tb_riscv_ai_chip_top;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   hbm_clk = 4'h0;
    logic [3:0]   hbm_rst_n;
    logic [255:0] hbm_dq;
    logic [3:0]   hbm_valid;
    logic [3:0]   hbm_ready;
    logic         pcie_clk = 1'b0;
    logic         pcie_rst_n;
    logic [15:0]  pcie_rx_p, pcie_rx_n;
    logic [15:0]  pcie_tx_p, pcie_tx_n;

    always #5 clk = ~clk;
    always #5 hbm_clk = ~hbm_clk;
    always #4 pcie_clk = ~pcie_clk;

    riscv_ai_chip_top #(
        .HBM_CHANNELS   (4),
        .HBM_DATA_WIDTH (64),
        .PCIE_LANES     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hbm_clk    (hbm_clk),
        .hbm_rst_n  (hbm_rst_n),
        .hbm_dq     (hbm_dq),
        .hbm_valid  (hbm_valid),
        .hbm_ready  (hbm_ready),
        .pcie_clk   (pcie_clk),
        .pcie_rst_n (pcie_rst_n),
        .pcie_rx_p  (pcie_rx_p),
        .pcie_rx_n  (pcie_rx_n),
        .pcie_tx_p  (pcie_tx_p),
        .pcie_tx_n  (pcie_tx_n)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int dut_acc = 0;

    // Behavioural reference: per-channel shift buffers, front entry at index 0.
    logic [3:0]  m_en;
    logic [63:0] m_buf [4][4];
    int          m_cnt [4];
    int          m_rr;
    logic [31:0] m_csum;
    logic [15:0] m_txp, m_txn;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  hrst;
        logic [3:0]  vld;
        logic [63:0] d0, d1, d2;
        logic [3:0]  e_rdy;
        logic [15:0] e_txp, e_txn;
        logic [31:0] e_csum;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic r, input logic [3:0] hr,
                                input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic [3:0] er, input logic [15:0] etp,
                                input logic [15:0] etn, input logic [31:0] ecs);
        vec_t t;
        t.name = nm; t.rst_n = r; t.hrst = hr; t.vld = v;
        t.d0 = a; t.d1 = b; t.d2 = c;
        t.e_rdy = er; t.e_txp = etp; t.e_txn = etn; t.e_csum = ecs;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en   = '0;
        m_rr   = 0;
        m_csum = '0;
        m_txp  = '0;
        m_txn  = '0;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            for (int j = 0; j < 4; j++) m_buf[c][j] = '0;
        end
    endtask

    // Advance one clock: update the reference from the present inputs, then sample #1 after the edge.
    task automatic cycle();
        logic [3:0]  rdy;
        logic [63:0] w;
        logic [15:0] ntx;
        int          sel;
        int          ch;
        for (int c = 0; c < 4; c++) if (hbm_valid[c] && hbm_ready[c]) dut_acc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < 4; c++) rdy[c] = m_en[c] && (m_cnt[c] < 4);
            sel = -1;
            for (int k = 0; k < 4; k++) begin
                ch = (m_rr + k) % 4;
                if (sel < 0 && m_en[ch] && m_cnt[ch] > 0) sel = ch;
            end
            ntx   = (pcie_rst_n && (&(pcie_rx_p ^ pcie_rx_n))) ? m_csum[15:0] : 16'h0;
            m_txn = pcie_rst_n ? ~ntx : 16'h0;
            m_txp = ntx;
            if (sel >= 0) begin
                w = m_buf[sel][0];
                for (int j = 0; j < 3; j++) m_buf[sel][j] = m_buf[sel][j+1];
                m_cnt[sel]--;
                m_csum = {m_csum[30:0], m_csum[31]} ^ (w[31:0] ^ w[63:32]);
                m_rr   = (sel + 1) % 4;
            end
            for (int c = 0; c < 4; c++) begin
                if (hbm_valid[c] && rdy[c]) begin
                    m_buf[c][m_cnt[c]] = hbm_dq[c*64 +: 64];
                    m_cnt[c]++;
                end
            end
            for (int c = 0; c < 4; c++) if (!m_en[c]) m_cnt[c] = 0;
            m_en = hbm_rst_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        logic [3:0] er;
        for (int c = 0; c < 4; c++) er[c] = m_en[c] && (m_cnt[c] < 4);
        chk({tag, ".rdy"},  64'(hbm_ready),    64'(er));
        chk({tag, ".txp"},  64'(pcie_tx_p),    64'(m_txp));
        chk({tag, ".txn"},  64'(pcie_tx_n),    64'(m_txn));
        chk({tag, ".csum"}, 64'(dut.csum_q),   64'(m_csum));
    endtask

    vec_t tv [10];

    initial begin
        logic [31:0] saved;
        int          first_block;

        tv[0] = mk("en_load", 1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0000, 16'hFFFF, 32'h0);
        tv[1] = mk("push_c0", 1'b1, 4'hF, 4'h1, 64'h00000001_00000000, 64'h0, 64'h0,
                   4'hF, 16'h0000, 16'hFFFF, 32'h0);
        tv[2] = mk("pop_c0",  1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0000, 16'hFFFF, 32'h1);
        tv[3] = mk("tx_c0",   1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0001, 16'hFFFE, 32'h1);
        tv[4] = mk("rst_mid", 1'b0, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'h0, 16'h0000, 16'h0000, 32'h0);
        tv[5] = mk("rst_rel", 1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0000, 16'hFFFF, 32'h0);
        tv[6] = mk("push_12", 1'b1, 4'hF, 4'h6, 64'h0, 64'h1, 64'h2, 4'hF, 16'h0000, 16'hFFFF, 32'h0);
        tv[7] = mk("pop_c1",  1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0000, 16'hFFFF, 32'h1);
        tv[8] = mk("pop_c2",  1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0001, 16'hFFFE, 32'h0);
        tv[9] = mk("idle",    1'b1, 4'hF, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 16'h0000, 16'hFFFF, 32'h0);

        rst_n      = 1'b0;
        hbm_rst_n  = 4'h0;
        hbm_valid  = 4'h0;
        hbm_dq     = '0;
        pcie_rst_n = 1'b1;
        pcie_rx_p  = 16'h0000;
        pcie_rx_n  = 16'hFFFF;
        model_reset();

        // Reset held: every output stays low.
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("reset_outs", {28'h0, hbm_ready, pcie_tx_p, pcie_tx_n}, 64'h0);
        end

        // Single word, mid-run reset, then two-channel ordering.
        for (int i = 0; i < 10; i++) begin
            rst_n     = tv[i].rst_n;
            hbm_rst_n = tv[i].hrst;
            hbm_valid = tv[i].vld;
            hbm_dq    = {64'h0, tv[i].d2, tv[i].d1, tv[i].d0};
            cycle();
            chk({tv[i].name, ".rdy"},  64'(hbm_ready),  64'(tv[i].e_rdy));
            chk({tv[i].name, ".txp"},  64'(pcie_tx_p),  64'(tv[i].e_txp));
            chk({tv[i].name, ".txn"},  64'(pcie_tx_n),  64'(tv[i].e_txn));
            chk({tv[i].name, ".csum"}, 64'(dut.csum_q), 64'(tv[i].e_csum));
        end

        // Saturation: all channels valid with random data.
        dut_acc     = 0;
        first_block = 0;
        hbm_valid   = 4'hF;
        for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < 8; c++) hbm_dq[c*32 +: 32] = $urandom;
            cycle();
            cmp_model("bp");
            if (first_block == 0 && hbm_ready != 4'hF) first_block = i + 1;
        end
        chk("bp_ready_drop_within_6", 64'(first_block >= 1 && first_block <= 6), 64'h1);
        chk("bp_accepted_le_116", 64'(dut_acc <= 116), 64'h1);

        // Channel 3 flush with words still queued.
        hbm_valid = 4'h7;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 8; c++) hbm_dq[c*32 +: 32] = $urandom;
            cycle();
            cmp_model("fill");
        end
        hbm_valid = 4'h0;
        hbm_rst_n = 4'h7;
        cycle();
        cmp_model("flush");
        chk("flush_ready3_low", 64'(hbm_ready[3]), 64'h0);
        cycle();
        cmp_model("flush_hold");
        hbm_rst_n = 4'hF;
        for (int i = 0; i < 18; i++) begin
            cycle();
            cmp_model("drain");
        end

        // Link drop on lane 5, then PCIe soft reset.
        pcie_rx_p = 16'h0020;
        cycle();
        cmp_model("link_down");
        chk("link_down_txp_zero", 64'(pcie_tx_p), 64'h0);
        pcie_rx_p = 16'h0000;
        cycle();
        cmp_model("link_up");
        saved      = dut.csum_q;
        pcie_rst_n = 1'b0;
        cycle();
        cmp_model("prst");
        chk("prst_txp_zero", 64'(pcie_tx_p), 64'h0);
        chk("prst_txn_zero", 64'(pcie_tx_n), 64'h0);
        cycle();
        pcie_rst_n = 1'b1;
        cycle();
        cycle();
        cmp_model("prst_rel");
        chk("prst_csum_kept", 64'(pcie_tx_p), 64'(m_csum[15:0]));

        // Asynchronous reset mid-cycle clears state without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {28'h0, hbm_ready, pcie_tx_p, pcie_tx_n}, 64'h0);
        chk("arst_csum", 64'(dut.csum_q), 64'h0);
        model_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
